// File: rtl/mac_seq_pkg.sv
// Shared widths, FSM states and MAC mode encoding for the mac_seq slice.
package mac_seq_pkg;

  localparam int unsigned BW      = 4;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned LEN_BW  = 8;

  localparam logic MODE_4B = 1'b0;
  localparam logic MODE_2B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mac_seq_mac.sv
// Combinational multiply-accumulate: c plus one beat of activation x weight,
// either two 2-bit fields with separate weights or one 4-bit field.
module mac
  import mac_seq_pkg::*;
(
  input  logic        [BW-1:0]      a,
  input  logic signed [BW-1:0]      b0,
  input  logic signed [BW-1:0]      b1,
  input  logic signed [PSUM_BW-1:0] c,
  input  logic                      mode,
  output logic signed [PSUM_BW-1:0] out
);

  localparam int unsigned HALF = BW / 2;

  logic signed [PSUM_BW-1:0] lo_x, hi_x, b0_x, b1_x, p_lo, p_hi;

  // Activation fields are unsigned (zero-extended); weights are sign-extended.
  always_comb begin
    lo_x = PSUM_BW'(a[HALF-1:0]);
    hi_x = PSUM_BW'(a[BW-1:HALF]);
    b0_x = PSUM_BW'(b0);
    b1_x = PSUM_BW'(b1);
    p_lo = lo_x * b0_x;
    if (mode == MODE_2B) begin
      p_hi = hi_x * b1_x;
    end else begin
      p_hi = (hi_x * b0_x) <<< 2;
    end
    out = c + p_lo + p_hi;
  end

endmodule

// File: rtl/mac_seq.sv
// Sequencer streaming activation/weight beats through one shared mac and
// presenting the accumulated dot product on a valid/ready output port.
module mac_seq
  import mac_seq_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_BW-1:0]  cfg_len,
  input  logic               cfg_mode_2b,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BW-1:0]      in_act,
  input  logic [BW-1:0]      in_w0,
  input  logic [BW-1:0]      in_w1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PSUM_BW-1:0] out_psum
);

  state_e              state_q, state_d;
  logic [PSUM_BW-1:0]  acc_q, acc_d;
  logic [LEN_BW-1:0]   cnt_q, cnt_d;
  logic [LEN_BW-1:0]   len_q, len_d;
  logic                mode_q, mode_d;
  logic [BW-1:0]       mac_b1;
  logic [PSUM_BW-1:0]  mac_out;

  assign mac_b1 = (mode_q == MODE_2B) ? in_w1 : in_w0;

  mac u_mac (
    .a    (in_act),
    .b0   (in_w0),
    .b1   (mac_b1),
    .c    (acc_q),
    .mode (mode_q),
    .out  (mac_out)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          mode_d  = cfg_mode_2b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (in_valid && in_ready) begin
          acc_d = mac_out;
          cnt_d = cnt_q + LEN_BW'(1);
          if (cnt_q == len_q - LEN_BW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      mode_q    <= MODE_4B;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      busy      <= (state_d != IDLE);
      in_ready  <= (state_d == RUN);
      out_valid <= (state_d == DONE);
    end
  end

  assign out_psum = acc_q;

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: stimulus queues expected sums, a negedge
// monitor pops and compares on every output handshake.
module tb_mac_seq;
  import mac_seq_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [LEN_BW-1:0]  cfg_len;
  logic               cfg_mode_2b;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [BW-1:0]      in_act;
  logic [BW-1:0]      in_w0;
  logic [BW-1:0]      in_w1;
  logic               out_valid;
  logic               out_ready;
  logic [PSUM_BW-1:0] out_psum;

  int checks = 0;
  int errors = 0;
  logic [PSUM_BW-1:0] exp_q[$];
  logic               prev_hold = 1'b0;
  logic [PSUM_BW-1:0] prev_psum = '0;

  mac_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_len     (cfg_len),
    .cfg_mode_2b (cfg_mode_2b),
    .busy        (busy),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_act      (in_act),
    .in_w0       (in_w0),
    .in_w1       (in_w1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_psum    (out_psum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: invariants, hold stability, and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      check("ready_valid_exclusive", 32'(in_ready && out_valid), 32'd0);
      if (prev_hold && out_valid) begin
        check("psum_stable", 32'(out_psum), 32'(prev_psum));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%0h with empty scoreboard", out_psum);
        end else begin
          check("psum", 32'(out_psum), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_psum = out_psum;
    end
  end

  task automatic do_start(input int len, input bit mode);
    start       = 1'b1;
    cfg_len     = LEN_BW'(len);
    cfg_mode_2b = mode;
    @(posedge clk);
    #1;
    start       = 1'b0;
    cfg_len     = 8'hAA;
    cfg_mode_2b = ~mode;
    check("busy_after_start", 32'(busy), 32'd1);
    check("in_ready_after_start", 32'(in_ready), 32'(len != 0));
    check("out_valid_after_start", 32'(out_valid), 32'(len == 0));
  endtask

  task automatic feed(input int n, input bit rnd, input int a, input int w0, input int w1);
    int  got = 0;
    int  budget = 0;
    bit  hs;
    in_act = BW'(a);
    in_w0  = BW'(w0);
    in_w1  = BW'(w1);
    while (got < n && budget < 4000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) got++;
      budget++;
    end
    in_valid = 1'b0;
    check("beats_accepted", 32'(got), 32'(n));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("returns_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input int len, input bit mode, input int a, input int w0,
                        input int w1, input bit rnd, input int expv);
    exp_q.push_back(PSUM_BW'(expv));
    do_start(len, mode);
    if (len > 0) begin
      feed(len, rnd, a, w0, w1);
      check("out_valid_after_last", 32'(out_valid), 32'd1);
      check("in_ready_after_last", 32'(in_ready), 32'd0);
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_mode_2b = 1'b0;
    in_valid = 1'b0; in_act = '0; in_w0 = '0; in_w1 = '0; out_ready = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_psum", 32'(out_psum), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 4-bit mode: 3 x (15 * -8) = -360
    run_op(3, MODE_4B, 15, -8, 0, 1'b0, -360);
    // 2-bit mode: 2*(-8) + 3*7 = 5
    run_op(1, MODE_2B, 4'b1110, -8, 7, 1'b0, 5);
    // 2-bit mode, negative w0 and positive w1: 2 x (3*(-2) + 1*5) = -2
    run_op(2, MODE_2B, 4'b0111, -2, 5, 1'b0, -2);
    // zero-length operation
    run_op(0, MODE_4B, 0, 0, 0, 1'b0, 0);
    // full length with random in_valid gaps: 255 x -120 = -30600
    run_op(255, MODE_4B, 15, -8, 0, 1'b1, -30600);

    // Output back-pressure with start pulsed in DONE: 2 x (1 * 5) = 10
    out_ready = 1'b0;
    exp_q.push_back(PSUM_BW'(10));
    do_start(2, MODE_4B);
    feed(2, 1'b0, 1, 5, 0);
    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      cfg_len = LEN_BW'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    check("hold_psum", 32'(out_psum), 32'd10);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_handshake", 32'(busy), 32'd0);
    check("no_valid_after_handshake", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("start_in_done_ignored", 32'(busy), 32'd0);

    // Reset after 2 of 4 beats discards the partial sum
    do_start(4, MODE_4B);
    feed(2, 1'b0, 15, -8, 0);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_psum", 32'(out_psum), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op(1, MODE_4B, 1, 3, 0, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
